// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the byte-lane helper used by AHB responders.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Lanes follow the little-endian AHB byte-lane mapping; illegal sizes enable nothing.
  function automatic logic [3:0] ahb_byte_en(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised flop memory with per-byte write enables and an asynchronous read port.
module ahb_sram_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB3-Lite SRAM responder: programmable OKAY wait states and a two-cycle ERROR response.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int MEM_SIZE    = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic        s_hsel_i,
  input  logic [31:0] s_haddr_i,
  input  logic [1:0]  s_htrans_i,
  input  logic        s_hwrite_i,
  input  logic [2:0]  s_hsize_i,
  input  logic [31:0] s_hwdata_i,
  input  logic        s_hready_i,
  output logic [31:0] s_hrdata_o,
  output logic        s_hreadyout_o,
  output logic        s_hresp_o
);

  localparam int AW    = $clog2(MEM_SIZE);
  localparam int WW    = (AW > 2) ? AW - 2 : 1;
  localparam int DEPTH = MEM_SIZE / 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic          err_q;
  logic          active_q;

  logic          accept;
  logic          err_new;
  logic          done;
  logic [3:0]    mem_be;
  logic [WW-1:0] word_addr;
  logic [31:0]   mem_rdata;
  logic          unused_ok;

  assign accept    = s_hsel_i & s_hready_i & s_htrans_i[1];
  assign unused_ok = ^{s_haddr_i >> AW, s_htrans_i[0]};

  always_comb begin
    err_new = 1'b0;
    case (s_hsize_i)
      HSIZE_BYTE: err_new = 1'b0;
      HSIZE_HALF: err_new = s_haddr_i[0];
      HSIZE_WORD: err_new = |s_haddr_i[1:0];
      default:    err_new = 1'b1;
    endcase
  end

  // ERR2 completes the error, so a transfer accepted there follows the IDLE rules.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (err_new) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q   <= s_haddr_i[AW-1:0];
        write_q  <= s_hwrite_i;
        size_q   <= s_hsize_i;
        err_q    <= err_new;
        active_q <= 1'b1;
      end else if (s_hready_i) begin
        err_q    <= 1'b0;
        active_q <= 1'b0;
      end
    end
  end

  // The completing cycle of an OKAY data phase is the only time memory is touched.
  assign done      = (state_q == ST_IDLE) & active_q & ~err_q;
  assign mem_be    = (done & write_q) ? ahb_byte_en(size_q, addr_q[1:0]) : 4'b0000;
  assign word_addr = WW'(addr_q >> 2);

  ahb_sram_array #(
    .DEPTH (DEPTH),
    .AW    (WW)
  ) u_array (
    .clk_i   (s_clk_i),
    .addr_i  (word_addr),
    .be_i    (mem_be),
    .wdata_i (s_hwdata_i),
    .rdata_o (mem_rdata)
  );

  assign s_hrdata_o    = (done & ~write_q) ? mem_rdata : 32'h0;
  assign s_hreadyout_o = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign s_hresp_o     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule
